// File: rtl/pipe_hazard_ctrl.sv
// Hazard and redirect control for a 5-stage MIPS-style pipeline: load-use and
// mult/div stalls, exception and eret redirects, and a stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lw_use_D,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  input  logic        md_use_D,
  input  logic        exc_req_M,
  input  logic        eret_D,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        fd_en,
  output logic        fd_clr,
  output logic        de_clr,
  output logic        em_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

  localparam logic [1:0] PcSelNormal = 2'd0;
  localparam logic [1:0] PcSelExcVec = 2'd1;
  localparam logic [1:0] PcSelEpc    = 2'd2;

  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall;

  assign md_busy   = (md_cnt_q != 4'd0);
  assign stall_cnt = stall_cnt_q;
  assign stall     = lw_use_D | (md_use_D & (md_busy | md_start_E));

  // A start is accepted only when the unit is idle and the starting
  // instruction is not being flushed by an exception in the same cycle.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_E && (md_cnt_q == 4'd0) && !exc_req_M) begin
      md_cnt_d = md_is_div_E ? DivLoad : MultLoad;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !exc_req_M) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Priority: reset, exception, stall, eret, then normal flow.
  // A stalled eret simply waits; its redirect happens once the stall clears.
  always_comb begin
    pc_en  = 1'b1;
    pc_sel = PcSelNormal;
    fd_en  = 1'b1;
    fd_clr = 1'b0;
    de_clr = 1'b0;
    em_clr = 1'b0;
    if (reset) begin
      pc_en  = 1'b0;
      fd_en  = 1'b0;
      fd_clr = 1'b1;
      de_clr = 1'b1;
      em_clr = 1'b1;
    end else if (exc_req_M) begin
      pc_sel = PcSelExcVec;
      fd_clr = 1'b1;
      de_clr = 1'b1;
      em_clr = 1'b1;
    end else if (stall) begin
      pc_en  = 1'b0;
      fd_en  = 1'b0;
      de_clr = 1'b1;
    end else if (eret_D) begin
      pc_sel = PcSelEpc;
      fd_clr = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: each step pushes its expected
// outputs into a queue, which is popped and compared once the outputs settle.
module tb_pipe_hazard_ctrl;

  typedef enum logic [2:0] {K_NORMAL, K_STALL, K_EXC, K_ERET, K_RESET} kind_e;

  typedef struct packed {
    logic  [6:0] ctrl;
    logic        busy;
    logic [31:0] stallCnt;
    kind_e       kind;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        lwUseD, mdStartE, mdIsDivE, mdUseD, excReqM, eretD;
  logic        pcEn, fdEn, fdClr, deClr, emClr, mdBusy;
  logic [1:0]  pcSel;
  logic [31:0] stallCnt;

  exp_t        expQ[$];
  logic [31:0] expStall;
  int          checks;
  int          errors;
  int          stepNum;

  pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .lw_use_D   (lwUseD),
    .md_start_E (mdStartE),
    .md_is_div_E(mdIsDivE),
    .md_use_D   (mdUseD),
    .exc_req_M  (excReqM),
    .eret_D     (eretD),
    .pc_en      (pcEn),
    .pc_sel     (pcSel),
    .fd_en      (fdEn),
    .fd_clr     (fdClr),
    .de_clr     (deClr),
    .em_clr     (emClr),
    .md_busy    (mdBusy),
    .stall_cnt  (stallCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packed as {pc_en, pc_sel[1:0], fd_en, fd_clr, de_clr, em_clr}.
  function automatic logic [6:0] ctrlFor(input kind_e k);
    case (k)
      K_STALL: return 7'b0_00_0_0_1_0;
      K_EXC:   return 7'b1_01_1_1_1_1;
      K_ERET:  return 7'b1_10_1_1_0_0;
      K_RESET: return 7'b0_00_0_1_1_1;
      default: return 7'b1_00_1_0_0_0;
    endcase
  endfunction

  task automatic applyStimulus(input logic lw, input logic start, input logic isDiv,
                               input logic use_, input logic exc, input logic eret,
                               input logic rst, input kind_e kind, input logic busy);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    lwUseD   = lw;
    mdStartE = start;
    mdIsDivE = isDiv;
    mdUseD   = use_;
    excReqM  = exc;
    eretD    = eret;
    e.ctrl     = ctrlFor(kind);
    e.busy     = busy;
    e.stallCnt = expStall;
    e.kind     = kind;
    expQ.push_back(e);
    stepNum++;
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [6:0] obsCtrl;
    #2;
    checks++;
    assert (expQ.size() != 0) else begin
      errors++;
      $error("[TB] FAIL step%0d queue: observed empty, expected entry", stepNum);
    end
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      obsCtrl = {pcEn, pcSel, fdEn, fdClr, deClr, emClr};
      checks++;
      assert (obsCtrl === e.ctrl) else begin
        errors++;
        $error("[TB] FAIL step%0d ctrl: observed %b, expected %b", stepNum, obsCtrl, e.ctrl);
      end
      checks++;
      assert (mdBusy === e.busy) else begin
        errors++;
        $error("[TB] FAIL step%0d md_busy: observed %b, expected %b", stepNum, mdBusy, e.busy);
      end
      checks++;
      assert (stallCnt === e.stallCnt) else begin
        errors++;
        $error("[TB] FAIL step%0d stall_cnt: observed %0d, expected %0d", stepNum, stallCnt, e.stallCnt);
      end
      if (e.kind == K_RESET) expStall = 32'd0;
      else if (e.kind == K_STALL) expStall = expStall + 32'd1;
    end
  endtask

  task automatic step(input logic lw, input logic start, input logic isDiv,
                      input logic use_, input logic exc, input logic eret,
                      input logic rst, input kind_e kind, input logic busy);
    applyStimulus(lw, start, isDiv, use_, exc, eret, rst, kind, busy);
    checkOutput();
  endtask

  task automatic checkStallCnt(input logic [31:0] want, input string tag);
    checks++;
    assert (stallCnt === want) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, stallCnt, want);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    stepNum  = 0;
    expStall = 32'd0;
    reset    = 1'b1;
    lwUseD   = 1'b0;
    mdStartE = 1'b0;
    mdIsDivE = 1'b0;
    mdUseD   = 1'b0;
    excReqM  = 1'b0;
    eretD    = 1'b0;

    // Reset dominates even with exception/eret/hazard inputs present.
    step(1, 0, 0, 0, 1, 1, 1, K_RESET,  0);
    step(0, 0, 0, 0, 0, 0, 0, K_NORMAL, 0);

    // Multiply followed by a dependent mfhi: start cycle + 5 busy cycles stall.
    step(0, 1, 0, 1, 0, 0, 0, K_STALL,  0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0, K_STALL, 1);
    step(0, 0, 0, 1, 0, 0, 0, K_NORMAL, 0);
    checkStallCnt(32'd6, "mult_stall_total");

    // Single load-use bubble.
    step(1, 0, 0, 0, 0, 0, 0, K_STALL,  0);
    step(0, 0, 0, 0, 0, 0, 0, K_NORMAL, 0);
    checkStallCnt(32'd7, "load_use_total");

    // Exception beats a load-use stall and squashes the mult start.
    step(1, 1, 0, 0, 1, 0, 0, K_EXC,    0);
    step(0, 0, 0, 0, 0, 0, 0, K_NORMAL, 0);
    checkStallCnt(32'd7, "exc_no_count");

    // Divide; a second start at busy cycle 3 must not reload.
    step(0, 1, 1, 0, 0, 0, 0, K_NORMAL, 0);
    step(0, 0, 0, 0, 0, 0, 0, K_NORMAL, 1);
    step(0, 0, 0, 0, 0, 0, 0, K_NORMAL, 1);
    step(0, 1, 1, 0, 0, 0, 0, K_NORMAL, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0, 0, K_NORMAL, 1);
    step(0, 0, 0, 0, 0, 0, 0, K_NORMAL, 0);

    // eret behind an mfhi-type use waits for the unit, then redirects once.
    step(0, 1, 0, 0, 0, 0, 0, K_NORMAL, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 1, 0, K_STALL, 1);
    step(0, 0, 0, 1, 0, 1, 0, K_ERET,   0);
    step(0, 0, 0, 0, 0, 0, 0, K_NORMAL, 0);
    checkStallCnt(32'd12, "eret_stall_total");

    // Exception during a busy stall flushes but does not stop the countdown.
    step(0, 1, 0, 0, 0, 0, 0, K_NORMAL, 0);
    step(0, 0, 0, 1, 1, 0, 0, K_EXC,    1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, K_NORMAL, 1);
    step(0, 0, 0, 0, 0, 0, 0, K_NORMAL, 0);

    // Reset in the middle of a divide aborts it and clears the counter.
    step(0, 1, 1, 0, 0, 0, 0, K_NORMAL, 0);
    step(0, 0, 0, 0, 0, 0, 0, K_NORMAL, 1);
    step(0, 0, 0, 0, 0, 0, 0, K_NORMAL, 1);
    step(0, 0, 0, 0, 0, 0, 0, K_NORMAL, 1);
    step(0, 0, 0, 1, 0, 0, 1, K_RESET,  1);
    step(0, 0, 0, 1, 0, 0, 0, K_NORMAL, 0);
    checkStallCnt(32'd0, "post_reset_count");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
